// File: rtl/tempo_pkg.sv
// Shared definitions for the tempo scheduler: counter width and FSM encoding.
package tempo_pkg;

  localparam int unsigned TEMPO_WIDTH = 7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/tempo_cnt.sv
// Shared time base: WIDTH-bit up counter with synchronous clear and enable.
module tempo_cnt #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  // Clear has priority so a new grant always starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tempo_sched.sv
// Round-robin owner of the shared tempo counter: grants one requester an
// interval of dur cycles and pulses its done at the end.
module tempo_sched
  import tempo_pkg::*;
#(
  parameter int unsigned WIDTH = TEMPO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] dur0,
  input  logic [WIDTH-1:0] dur1,
  input  logic             pausa,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [WIDTH-1:0] tempo
);

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic             busy_q, busy_d;
  logic             cnt_clr_c, cnt_en_c;
  logic             pick1_c, owner_req_c, last_c;
  logic [WIDTH-1:0] tempo_w;

  // Arbitration and owner status are decoded from registered state only.
  assign pick1_c     = (req0 && req1) ? rr_q : req1;
  assign owner_req_c = gnt1_q ? req1 : req0;
  assign last_c      = (tempo_w == WIDTH'(target_q - WIDTH'(1)));

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    target_d  = target_q;
    gnt0_d    = gnt0_q;
    gnt1_d    = gnt1_q;
    cnt_clr_c = 1'b0;
    cnt_en_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          target_d  = pick1_c ? dur1 : dur0;
          gnt0_d    = !pick1_c;
          gnt1_d    = pick1_c;
          cnt_clr_c = 1'b1;
          state_d   = (target_d == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // A withdrawn request beats completion in the same cycle.
        if (!owner_req_c) begin
          state_d   = IDLE;
          gnt0_d    = 1'b0;
          gnt1_d    = 1'b0;
          cnt_clr_c = 1'b1;
          rr_d      = !gnt1_q;
        end else if (!pausa) begin
          if (last_c) begin
            state_d = DONE;
          end else begin
            cnt_en_c = 1'b1;
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        cnt_clr_c = 1'b1;
        rr_d      = !gnt1_q;
      end
      default: begin
        state_d   = IDLE;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        cnt_clr_c = 1'b1;
      end
    endcase
  end

  // done is raised on entry to DONE so it lines up with the DONE cycle.
  always_comb begin
    done0_d = (state_d == DONE) && gnt0_d;
    done1_d = (state_d == DONE) && gnt1_d;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      target_q <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      target_q <= target_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
    end
  end

  tempo_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr_c),
    .en_i  (cnt_en_c),
    .cnt_o (tempo_w)
  );

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign busy  = busy_q;
  assign tempo = tempo_w;

endmodule

// File: tb/tb_tempo_sched.sv
// Self-checking bench for tempo_sched: directed scenarios plus random traffic
// against an interval-level reference model.
module tb_tempo_sched;

  localparam int unsigned W = 7;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0, pausa = 1'b0;
  logic [W-1:0] dur0 = '0, dur1 = '0;
  logic         gnt0, gnt1, done0, done1, busy;
  logic [W-1:0] tempo;

  int checks = 0;
  int errors = 0;

  tempo_sched #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .req1  (req1),
    .dur0  (dur0),
    .dur1  (dur1),
    .pausa (pausa),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .busy  (busy),
    .tempo (tempo)
  );

  always #5 clk = ~clk;

  // Reference: one interval record (owner, length, counted cycles, finishing).
  bit m_act, m_fin, m_own, m_rr;
  int m_dur, m_ticks;

  function automatic void model_reset();
    m_act = 0; m_fin = 0; m_own = 0; m_rr = 0; m_dur = 0; m_ticks = 0;
  endfunction

  function automatic void model_step();
    bit own_req;
    own_req = m_own ? req1 : req0;
    if (m_fin) begin
      m_fin = 0; m_act = 0; m_rr = !m_own;
    end else if (m_act) begin
      if (!own_req) begin
        m_act = 0; m_rr = !m_own;
      end else if (!pausa) begin
        if (m_ticks + 1 >= m_dur) m_fin = 1;
        else m_ticks++;
      end
    end else if (req0 || req1) begin
      m_own   = (req0 && req1) ? m_rr : req1;
      m_dur   = m_own ? int'(dur1) : int'(dur0);
      m_ticks = 0;
      m_act   = 1;
      m_fin   = (m_dur == 0);
    end
  endfunction

  function automatic logic [11:0] model_out();
    return {m_act && !m_own, m_act && m_own, m_fin && !m_own, m_fin && m_own,
            m_act, m_act ? 7'(m_ticks) : 7'd0};
  endfunction

  function automatic logic [11:0] obs();
    return {gnt0, gnt1, done0, done1, busy, tempo};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic idle_all(input int n);
    req0 = 0; req1 = 0; pausa = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    checks++;
    if (obs() !== 12'h000) begin
      errors++; $display("FAIL reset_hold got %h exp %h", obs(), 12'h000);
    end
    #2 rst = 0;
    tick();
    checks++;
    if (obs() !== 12'h000) begin
      errors++; $display("FAIL reset_idle got %h exp %h", obs(), 12'h000);
    end
  endtask

  task automatic test_single();
    logic [11:0] exp;
    logic [6:0]  et;
    req0 = 1; dur0 = 7'd5;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) req0 = 0;
      et  = (k <= 5) ? 7'(k - 1) : ((k == 6) ? 7'd4 : 7'd0);
      exp = {k <= 6, 1'b0, k == 6, 1'b0, k <= 6, et};
      checks++;
      if (obs() !== exp) begin
        errors++; $display("FAIL single_dur5 k=%0d got %h exp %h", k, obs(), exp);
      end
    end
  endtask

  task automatic test_round_robin();
    int g[$];
    bit p0 = 0, p1 = 0;
    rst = 1; tick(); #2 rst = 0; tick();
    dur0 = 7'd3; dur1 = 7'd2; req0 = 1; req1 = 1;
    for (int c = 0; c < 30; c++) begin
      tick();
      checks++;
      if (obs() !== model_out()) begin
        errors++; $display("FAIL rr c=%0d got %h exp %h", c, obs(), model_out());
      end
      if (gnt0 && !p0) g.push_back(0);
      if (gnt1 && !p1) g.push_back(1);
      p0 = gnt0; p1 = gnt1;
      req0 = !done0;
      req1 = !done1;
    end
    checks++;
    if (g.size() < 4 || g[0] != 0 || g[1] != 1 || g[2] != 0 || g[3] != 1) begin
      errors++;
      $display("FAIL rr_order got n=%0d first=%0d,%0d,%0d,%0d exp 0,1,0,1", g.size(),
               g.size() > 0 ? g[0] : -1, g.size() > 1 ? g[1] : -1,
               g.size() > 2 ? g[2] : -1, g.size() > 3 ? g[3] : -1);
    end
    idle_all(3);
  endtask

  task automatic test_pausa();
    int n = 0, pc = 0, held = 0;
    bit armed = 0, seen = 0;
    req1 = 1; dur1 = 7'd4;
    for (int c = 1; c <= 30; c++) begin
      tick();
      checks++;
      if (obs() !== model_out()) begin
        errors++; $display("FAIL pausa c=%0d got %h exp %h", c, obs(), model_out());
      end
      if (gnt1 && tempo == 7'd2) held++;
      if (done1) begin n = c; seen = 1; req1 = 0; break; end
      if (pc > 0) begin pc--; if (pc == 0) pausa = 0; end
      if (tempo == 7'd2 && !armed) begin pausa = 1; pc = 3; armed = 1; end
    end
    checks++;
    if (!seen || n != 8 || held != 4) begin
      errors++; $display("FAIL pausa_latency got n=%0d held=%0d exp n=8 held=4", n, held);
    end
    idle_all(3);
  endtask

  task automatic test_abort();
    bit hit = 0, bad_done = 0, fin = 0;
    req0 = 1; dur0 = 7'd10;
    tick();
    req1 = 1; dur1 = 7'd3;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (obs() !== model_out()) begin
        errors++; $display("FAIL abort_run c=%0d got %h exp %h", c, obs(), model_out());
      end
      if (gnt0 && tempo == 7'd6) begin hit = 1; break; end
      tick();
    end
    req0 = 0;
    tick();
    checks++;
    if (!hit || obs() !== 12'h000) begin
      errors++; $display("FAIL abort_idle hit=%0d got %h exp %h", hit, obs(), 12'h000);
    end
    tick();
    checks++;
    if (obs() !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd0}) begin
      errors++; $display("FAIL abort_next_gnt1 got %h exp %h", obs(), {5'b01001, 7'd0});
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done0) bad_done = 1;
      if (done1) begin fin = 1; req1 = 0; break; end
    end
    checks++;
    if (bad_done || !fin) begin
      errors++; $display("FAIL abort_done got done0=%0d done1=%0d exp done0=0 done1=1", bad_done, fin);
    end
    idle_all(3);
  endtask

  task automatic test_boundary();
    int at = 0, mx = 0;
    req0 = 1; dur0 = 7'd0;
    tick();
    req0 = 0;
    checks++;
    if (obs() !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7'd0}) begin
      errors++; $display("FAIL dur0_zero got %h exp %h", obs(), {5'b10101, 7'd0});
    end
    tick();
    checks++;
    if (obs() !== 12'h000) begin
      errors++; $display("FAIL dur0_zero_idle got %h exp %h", obs(), 12'h000);
    end
    req0 = 1; dur0 = 7'd127;
    for (int c = 1; c <= 200; c++) begin
      tick();
      checks++;
      if (obs() !== model_out()) begin
        errors++; $display("FAIL dur127 c=%0d got %h exp %h", c, obs(), model_out());
      end
      if (int'(tempo) > mx) mx = int'(tempo);
      if (done0) begin at = c; req0 = 0; break; end
    end
    checks++;
    if (at != 128 || mx != 126) begin
      errors++; $display("FAIL dur127_end got done_at=%0d max=%0d exp 128 126", at, mx);
    end
    idle_all(3);
  endtask

  task automatic test_mid_reset();
    bit bad = 0;
    req0 = 1; dur0 = 7'd20;
    for (int c = 0; c < 6; c++) tick();
    #2 rst = 1;
    #1;
    checks++;
    if (obs() !== 12'h000) begin
      errors++; $display("FAIL async_reset got %h exp %h", obs(), 12'h000);
    end
    req0 = 0; req1 = 1; dur1 = 7'd3;
    tick();
    #2 rst = 0;
    tick();
    checks++;
    if (obs() !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd0}) begin
      errors++; $display("FAIL post_reset_gnt1 got %h exp %h", obs(), {5'b01001, 7'd0});
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done0) bad = 1;
      if (done1) req1 = 0;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL post_reset_done0 got 1 exp 0");
    end
    idle_all(3);
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      tick();
      checks++;
      if (obs() !== model_out()) begin
        errors++; $display("FAIL random c=%0d got %h exp %h", c, obs(), model_out());
      end
      if (done0) req0 = 0;
      else if (!req0) req0 = ($urandom_range(0, 2) == 0);
      else if (gnt0 && $urandom_range(0, 39) == 0) req0 = 0;
      if (done1) req1 = 0;
      else if (!req1) req1 = ($urandom_range(0, 2) == 0);
      else if (gnt1 && $urandom_range(0, 39) == 0) req1 = 0;
      dur0  = ($urandom_range(0, 9) < 8) ? 7'($urandom_range(0, 8)) : 7'($urandom_range(0, 127));
      dur1  = ($urandom_range(0, 9) < 8) ? 7'($urandom_range(0, 8)) : 7'($urandom_range(0, 127));
      pausa = ($urandom_range(0, 3) == 0);
    end
    idle_all(2);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_pausa();
    test_abort();
    test_boundary();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tempo_sched.md
# tempo_sched

Time-slot scheduler that shares a single 7-bit tempo counter between two requesters. Each requester asks for an interval of `dur` clock cycles. The scheduler grants one requester at a time in round-robin order and runs the counter from 0 for that interval. It pulses `done` for the served requester at the end. It sits between the game/control FSMs and the shared time base, replacing free-running counting with sequenced, owned intervals.

## Interface
Parameters:
- `WIDTH`, 7, width of the tempo counter and of the duration inputs.

Ports:
- `clk`, input, 1, single clock; all state is updated on the rising edge.
- `rst`, input, 1, asynchronous, active-high reset.
- `req0` / `req1`, input, 1, interval request; held high until the matching `done` or until withdrawn.
- `dur0` / `dur1`, input, WIDTH, requested interval length in cycles; sampled only on the grant decision.
- `pausa`, input, 1, freezes the counter while the FSM is in RUN.
- `gnt0` / `gnt1`, output, 1, registered grant (one-hot or zero).
- `done0` / `done1`, output, 1, one-cycle completion pulse.
- `busy`, output, 1, high in RUN and DONE.
- `tempo`, output, WIDTH, current count of the granted interval; 0 when idle.

## Operation
- **Reset values:** all outputs are 0, the FSM is in IDLE, the round-robin pointer `rr` is 0 (req0 favoured) and the target register is 0.
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - If exactly one `req` is high, that requester wins.
  - If both are high, the requester selected by `rr` wins.
  - The winner's `dur` is latched into `target`, its `gnt` is set and `tempo` is cleared.
  - Next state is RUN, or DONE if the latched `dur` is 0.
  - With no request, the FSM stays in IDLE.
- **RUN:**
  - `tempo` increments by 1 each cycle unless `pausa` is high.
  - When `tempo == target-1` and `pausa` is low, next state is DONE.
- **DONE:**
  - The granted requester's `done` is high for exactly one cycle; its `gnt` stays high.
  - Next state is IDLE, which clears `gnt` and `tempo`.
  - `rr` is set to the other requester.
- **Abort:**
  - If the granted `req` goes low in RUN, the next state is IDLE, with no `done`. `gnt` and `tempo` are cleared and `rr` is set to the other requester.
  - An abort in the last RUN cycle wins over completion.
  - A `req` drop during DONE does not suppress `done`.
- **Requester protocol:** the requester drops `req` in the cycle after `done`. If `req` is still high in IDLE, it is treated as a new request, subject to `rr`.
- **Width:** `tempo` never wraps. The maximum `dur` of 127 ends with `tempo` = 126.
- **`pausa`:** ignored in IDLE and DONE.
- **Mid-operation reset:** returns immediately to the reset values; no `done` is issued.

## Timing
- A request sampled in the IDLE cycle *t* gives:
  - `gnt` high from cycle *t+1*;
  - `tempo` = *k* in cycle *t+1+k*;
  - the last RUN cycle at *t+dur*;
  - `done` in cycle *t+dur+1*;
  - IDLE again in cycle *t+dur+2*.
- Request-to-`done` latency is `dur`+1 cycles plus the number of paused cycles in RUN.
- `dur` = 0 gives `done` in cycle *t+1*.
- The minimum spacing between two consecutive grants is 2 cycles: the DONE cycle, then the IDLE decision cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- **Package `tempo_pkg`:**
  - Localparams for the state encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - The default `WIDTH` = 7.
- **Sub-module `tempo_cnt`:**
  - WIDTH-bit counter with synchronous `clr` and `en`, and asynchronous `rst`.
  - Holds the shared time base and is instantiated once.
- **Top-level logic:** the FSM, the `rr` pointer, the target register and the grant/done registers stay in the top.

## Test plan
- Reset, then `req0` with `dur0`=5 → `gnt0` at t+1, `tempo` 0..4 over t+1..t+5, `done0` at t+6 only, `busy` low at t+7.
- `req0` and `req1` high together after reset, `dur0`=3, `dur1`=2 → req0 served first, then req1. Re-raising `req0` alongside `req1` favours req1.
- `dur1`=4 with `pausa` high for 3 cycles while `tempo`=2 → `tempo` holds at 2, and `done1` arrives 3 cycles later than t+5.
- `req0` with `dur0`=10 dropped while `tempo`=6 → no `done0`, IDLE next cycle, pending `req1` granted one cycle later.
- `dur0`=0 → `done0` at t+1. `dur0`=127 → `tempo` reaches 126, `done0` at t+128, no wrap.
- `rst` asserted mid-RUN → outputs 0 asynchronously. Release with `req1` held → `req1` granted normally, no `done` for the interrupted interval.
